// File: rtl/sfa_bif_sched_if.sv
// Scheduler <-> requester/BIF signal bundle. The scheduler sits on the slave side;
// the requesters, the stream taps and the BIF configuration sink sit on the master side.
interface sfa_bif_sched_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      REQ_VALID;
    logic [NREQ-1:0]      REQ_READY;
    logic [16*NREQ-1:0]   REQ_INDEX;
    logic [16*NREQ-1:0]   REQ_SIZE;
    logic [16*NREQ-1:0]   REQ_STRIDE;
    logic [NREQ-1:0]      REQ_MODE;
    logic [NREQ-1:0]      DONE;
    logic [NREQ-1:0]      ERR;
    logic [NREQ-1:0]      GRANT;
    logic                 BUSY;
    logic                 BIF_EN;
    logic [15:0]          INDEX;
    logic [15:0]          SIZE;
    logic [15:0]          STRIDE;
    logic                 MODE;
    logic                 mBIF_tvalid;
    logic                 mBIF_tready;
    logic                 sBIR_tvalid;
    logic                 sBIR_tready;

    modport slave (
        input  REQ_VALID, REQ_INDEX, REQ_SIZE, REQ_STRIDE, REQ_MODE,
        input  mBIF_tvalid, mBIF_tready, sBIR_tvalid, sBIR_tready,
        output REQ_READY, DONE, ERR, GRANT, BUSY, BIF_EN,
        output INDEX, SIZE, STRIDE, MODE
    );

    modport master (
        output REQ_VALID, REQ_INDEX, REQ_SIZE, REQ_STRIDE, REQ_MODE,
        output mBIF_tvalid, mBIF_tready, sBIR_tvalid, sBIR_tready,
        input  REQ_READY, DONE, ERR, GRANT, BUSY, BIF_EN,
        input  INDEX, SIZE, STRIDE, MODE
    );
endinterface

// File: rtl/sfa_bif_sched.sv
// Round-robin owner of one BRAM interface engine: arbitrates NREQ job descriptors,
// validates them, starts the BIF, counts stream beats and reports DONE/ERR per requester.
module sfa_bif_sched #(
    parameter int NREQ = 2
) (
    input  logic           ACLK,
    input  logic           ARESETN,
    sfa_bif_sched_if.slave bif
);
    localparam int PW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_ptr, w_ptr_nxt;
    logic [PW-1:0]   r_own, w_own_nxt;
    logic [NREQ-1:0] r_ready, w_ready_nxt;
    logic [NREQ-1:0] r_done, w_done_nxt;
    logic [NREQ-1:0] r_errp, w_errp_nxt;
    logic [NREQ-1:0] r_grant, w_grant_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_bif_en, w_bif_en_nxt;
    logic            r_rej, w_rej_nxt;
    logic            r_mode, w_mode_nxt;
    logic [15:0]     r_index, w_index_nxt;
    logic [15:0]     r_size, w_size_nxt;
    logic [15:0]     r_stride, w_stride_nxt;
    logic [18:0]     r_acc, w_acc_nxt;
    logic [1:0]      r_drain, w_drain_nxt;

    logic            w_found;
    logic [PW-1:0]   w_win;
    logic [PW:0]     w_sum;
    logic [18:0]     w_step, w_end, w_lim, w_acc_step;
    logic            w_reject, w_beat;

    // Scan from r_ptr upward; iterating downward lets the nearest valid requester win.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(i);
            if (w_sum >= (PW+1)'(NREQ))
                w_sum = w_sum - (PW+1)'(NREQ);
            if (bif.REQ_VALID[w_sum[PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[PW-1:0];
            end
        end
    end

    // 19-bit byte arithmetic so a descriptor running past 64 KiB is visible, not wrapped.
    assign w_step     = {1'b0, r_stride, 2'b00};
    assign w_end      = {3'b000, r_index} + {1'b0, r_size, 2'b00};
    assign w_lim      = w_end + w_step;
    assign w_acc_step = r_acc + w_step;
    assign w_reject   = (r_size == 16'd0) || (r_stride == 16'd0) || (w_lim > 19'h10000);
    assign w_beat     = r_mode ? (bif.sBIR_tvalid & bif.sBIR_tready)
                               : (bif.mBIF_tvalid & bif.mBIF_tready);

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_own_nxt    = r_own;
        w_grant_nxt  = r_grant;
        w_busy_nxt   = r_busy;
        w_rej_nxt    = r_rej;
        w_mode_nxt   = r_mode;
        w_index_nxt  = r_index;
        w_size_nxt   = r_size;
        w_stride_nxt = r_stride;
        w_acc_nxt    = r_acc;
        w_drain_nxt  = r_drain;
        w_ready_nxt  = '0;
        w_done_nxt   = '0;
        w_errp_nxt   = '0;
        w_bif_en_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_own_nxt          = w_win;
                    w_index_nxt        = bif.REQ_INDEX[{w_win, 4'b0000} +: 16];
                    w_size_nxt         = bif.REQ_SIZE[{w_win, 4'b0000} +: 16];
                    w_stride_nxt       = bif.REQ_STRIDE[{w_win, 4'b0000} +: 16];
                    w_mode_nxt         = bif.REQ_MODE[w_win];
                    w_ready_nxt[w_win] = 1'b1;
                    w_grant_nxt        = NREQ'(1) << w_win;
                    w_busy_nxt         = 1'b1;
                    w_rej_nxt          = 1'b0;
                    w_state_nxt        = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_reject) begin
                    w_rej_nxt   = 1'b1;
                    w_state_nxt = S_FIN;
                end else begin
                    w_acc_nxt    = {3'b000, r_index};
                    w_bif_en_nxt = 1'b1;
                    w_state_nxt  = S_START;
                end
            end
            S_START: w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_beat) begin
                    w_acc_nxt = w_acc_step;
                    if (w_acc_step >= w_end) begin
                        // Time for the BIF to fall back to its fetch state after the last handshake.
                        w_drain_nxt = r_mode ? 2'd3 : 2'd2;
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                w_drain_nxt = r_drain - 2'd1;
                if (r_drain == 2'd1)
                    w_state_nxt = S_FIN;
            end
            S_FIN: begin
                if (r_rej)
                    w_errp_nxt[r_own] = 1'b1;
                else
                    w_done_nxt[r_own] = 1'b1;
                w_ptr_nxt   = (r_own == PW'(NREQ - 1)) ? '0 : r_own + 1'b1;
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_own    <= '0;
            r_ready  <= '0;
            r_done   <= '0;
            r_errp   <= '0;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_bif_en <= 1'b0;
            r_rej    <= 1'b0;
            r_mode   <= 1'b0;
            r_index  <= '0;
            r_size   <= '0;
            r_stride <= '0;
            r_acc    <= '0;
            r_drain  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_own    <= w_own_nxt;
            r_ready  <= w_ready_nxt;
            r_done   <= w_done_nxt;
            r_errp   <= w_errp_nxt;
            r_grant  <= w_grant_nxt;
            r_busy   <= w_busy_nxt;
            r_bif_en <= w_bif_en_nxt;
            r_rej    <= w_rej_nxt;
            r_mode   <= w_mode_nxt;
            r_index  <= w_index_nxt;
            r_size   <= w_size_nxt;
            r_stride <= w_stride_nxt;
            r_acc    <= w_acc_nxt;
            r_drain  <= w_drain_nxt;
        end
    end

    assign bif.REQ_READY = r_ready;
    assign bif.DONE      = r_done;
    assign bif.ERR       = r_errp;
    assign bif.GRANT     = r_grant;
    assign bif.BUSY      = r_busy;
    assign bif.BIF_EN    = r_bif_en;
    assign bif.INDEX     = r_index;
    assign bif.SIZE      = r_size;
    assign bif.STRIDE    = r_stride;
    assign bif.MODE      = r_mode;
endmodule

// File: tb/tb_sfa_bif_sched.sv
// Scoreboard bench for sfa_bif_sched: stimulus queues expected READY/DONE/ERR events,
// a negedge monitor pops and checks them along with BUSY/GRANT/BIF_EN consistency.
module tb_sfa_bif_sched;
    localparam int NREQ = 2;

    typedef struct {
        int kind;   // 0 ready, 1 done, 2 err
        int req;
        int cyc;    // -1: any cycle
    } exp_t;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    always #5 ACLK = ~ACLK;

    sfa_bif_sched_if #(.NREQ(NREQ)) bif();
    sfa_bif_sched #(.NREQ(NREQ)) dut (.ACLK(ACLK), .ARESETN(ARESETN), .bif(bif));

    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    exp_t q[$];

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic push_exp(input int kind, input int req, input int c);
        exp_t e;
        e.kind = kind;
        e.req  = req;
        e.cyc  = c;
        q.push_back(e);
    endtask

    function automatic int idx_of(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++)
            if (v[i]) r = (r == -1) ? i : -2;
        return r;
    endfunction

    task automatic ev_check(input string name, input int kind, input int req);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL %s: unexpected event kind=%0d req=%0d at cycle %0d, required none", name, kind, req, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.req != req || (e.cyc >= 0 && e.cyc != cyc)) begin
                fails++;
                $display("FAIL %s: got kind=%0d req=%0d cycle=%0d, expected kind=%0d req=%0d cycle=%0d",
                         name, kind, req, cyc, e.kind, e.req, e.cyc);
            end
        end
    endtask

    // Monitor: job bookkeeping from observed handshakes, independent of stimulus
    bit m_open = 1'b0;
    bit m_en   = 1'b0;
    int m_own  = 0;
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            m_open = 1'b0;
            m_en   = 1'b0;
        end else begin
            if (bif.REQ_READY != '0) begin
                chk("ready_while_busy", int'(m_open), 0);
                m_own = idx_of(bif.REQ_READY);
                ev_check("ready", 0, m_own);
                m_open = 1'b1;
                m_en   = 1'b0;
            end
            if (bif.BIF_EN) begin
                chk("bif_en_context", {m_open, m_en}, 2);
                m_en = 1'b1;
            end
            if (bif.DONE != '0) begin
                ev_check("done", 1, idx_of(bif.DONE));
                chk("done_had_bif_en", int'(m_en), 1);
                m_open = 1'b0;
            end
            if (bif.ERR != '0) begin
                ev_check("err", 2, idx_of(bif.ERR));
                chk("err_without_bif_en", int'(m_en), 0);
                m_open = 1'b0;
            end
            chk("busy", int'(bif.BUSY), int'(m_open));
            chk("grant", int'(bif.GRANT), (m_open && m_own >= 0) ? (1 << m_own) : 0);
        end
    end

    task automatic issue(input int k, input int idx, input int size, input int stride, input bit mode);
        bif.REQ_INDEX[16*k +: 16]  = idx[15:0];
        bif.REQ_SIZE[16*k +: 16]   = size[15:0];
        bif.REQ_STRIDE[16*k +: 16] = stride[15:0];
        bif.REQ_MODE[k]            = mode;
        bif.REQ_VALID[k]           = 1'b1;
    endtask

    task automatic drop(input int k);
        bif.REQ_VALID[k]           = 1'b0;
        bif.REQ_INDEX[16*k +: 16]  = 16'hDEAD;
        bif.REQ_SIZE[16*k +: 16]   = 16'h0000;
        bif.REQ_STRIDE[16*k +: 16] = 16'h0000;
        bif.REQ_MODE[k]            = ~bif.REQ_MODE[k];
    endtask

    task automatic wait_ready(input int k, output int c);
        c = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge ACLK);
            if (bif.REQ_READY[k]) begin
                c = cyc;
                break;
            end
        end
        checks++;
        if (c < 0) begin
            fails++;
            $display("FAIL ready_timeout: REQ_READY[%0d] absent for 50 cycles, required a pulse", k);
        end
    endtask

    task automatic wait_bif_en(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge ACLK);
            if (bif.BIF_EN) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL bif_en_timeout: BIF_EN absent for 50 cycles, required a pulse");
        end
    endtask

    // Drive n handshakes, each preceded by gap idle cycles; noise toggles the unused stream.
    task automatic serve(input bit mode, input int n, input int gap, input bit noise, output int last);
        last = -100;
        @(posedge ACLK); #1;
        if (mode) bif.sBIR_tvalid = 1'b1; else bif.mBIF_tvalid = 1'b1;
        if (noise) begin
            if (mode) begin bif.mBIF_tvalid = 1'b1; bif.mBIF_tready = 1'b1; end
            else      begin bif.sBIR_tvalid = 1'b1; bif.sBIR_tready = 1'b1; end
        end
        for (int b = 0; b < n; b++) begin
            for (int g = 0; g < gap; g++) begin @(posedge ACLK); #1; end
            if (mode) bif.sBIR_tready = 1'b1; else bif.mBIF_tready = 1'b1;
            last = cyc;
            @(posedge ACLK); #1;
            if (mode) bif.sBIR_tready = 1'b0; else bif.mBIF_tready = 1'b0;
        end
        if (noise) begin
            if (mode) bif.sBIR_tready = 1'b1; else bif.mBIF_tready = 1'b1;
            @(posedge ACLK); #1;
        end
        bif.mBIF_tvalid = 1'b0; bif.mBIF_tready = 1'b0;
        bif.sBIR_tvalid = 1'b0; bif.sBIR_tready = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout: %0d events still pending, required 0", tag, q.size());
            q.delete();
        end
        repeat (2) @(negedge ACLK);
    endtask

    task automatic job_ok(input int k, input int idx, input int size, input int stride, input bit mode,
                          input int n, input int gap, input bit noise);
        int c;
        bit ok;
        int last;
        push_exp(0, k, -1);
        issue(k, idx, size, stride, mode);
        wait_ready(k, c);
        drop(k);
        wait_bif_en(ok);
        if (ok) begin
            chk("cfg_index", int'(bif.INDEX), idx);
            chk("cfg_size", int'(bif.SIZE), size);
            chk("cfg_stride", int'(bif.STRIDE), stride);
            chk("cfg_mode", int'(bif.MODE), int'(mode));
            serve(mode, n, gap, noise, last);
            push_exp(1, k, last + (mode ? 5 : 4));
        end
        wait_empty("job");
    endtask

    task automatic job_err(input int k, input int idx, input int size, input int stride);
        int c;
        push_exp(0, k, -1);
        issue(k, idx, size, stride, 1'b0);
        wait_ready(k, c);
        drop(k);
        push_exp(2, k, c + 2);
        wait_empty("err");
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_handshake"}, int'({bif.REQ_READY, bif.DONE, bif.ERR, bif.GRANT, bif.BUSY, bif.BIF_EN}), 0);
        chk({tag, "_cfg"}, int'({bif.INDEX, bif.SIZE}), 0);
        chk({tag, "_cfg2"}, int'({bif.STRIDE, bif.MODE}), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  last;
        bit  ok;
        bif.REQ_VALID = '0; bif.REQ_INDEX = '0; bif.REQ_SIZE = '0;
        bif.REQ_STRIDE = '0; bif.REQ_MODE = '0;
        bif.mBIF_tvalid = 1'b0; bif.mBIF_tready = 1'b0;
        bif.sBIR_tvalid = 1'b0; bif.sBIR_tready = 1'b0;
        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        chk_all_zero("reset");
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);

        // 1: read, 4 beats, back-to-back handshakes
        job_ok(0, 16'h0010, 4, 1, 1'b0, 4, 0, 1'b0);
        // 2: write, ceil(5/2)=3 beats, read stream noise ignored
        job_ok(1, 16'h0000, 5, 2, 1'b1, 3, 0, 1'b1);

        // 3: both held, three 1-beat jobs each, strict alternation
        push_exp(0, 0, -1);
        issue(0, 16'h0100, 1, 1, 1'b0);
        issue(1, 16'h0200, 1, 1, 1'b0);
        for (int j = 0; j < 6; j++) begin
            wait_bif_en(ok);
            chk("rr_order", int'(bif.GRANT), 1 << (j % 2));
            if (j >= 4) bif.REQ_VALID[j % 2] = 1'b0;
            serve(1'b0, 1, 0, 1'b0, last);
            push_exp(1, j % 2, last + 4);
            if (j < 5) push_exp(0, 1 - (j % 2), -1);
        end
        wait_empty("rr");

        // 4: rejects, then the largest legal end address (LIM == 65536)
        job_err(1, 16'h0000, 0, 1);
        job_err(0, 16'h0000, 4, 0);
        job_err(1, 16'hFFF0, 4, 1);
        job_ok(0, 16'hFFEC, 4, 1, 1'b0, 4, 0, 1'b0);

        // 5: tready 1-in-3, write-stream noise and a DRAIN-time handshake ignored
        job_ok(0, 16'h0040, 3, 1, 1'b0, 3, 2, 1'b1);

        // 6: reset during RUN of a write job
        push_exp(0, 1, -1);
        issue(1, 16'h0000, 8, 1, 1'b1);
        wait_ready(1, last);
        drop(1);
        wait_bif_en(ok);
        serve(1'b1, 2, 0, 1'b0, last);
        ARESETN = 1'b0;
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        chk_all_zero("midrun_reset");
        repeat (10) @(negedge ACLK);
        push_exp(0, 0, -1);
        issue(0, 16'h0000, 1, 1, 1'b0);
        issue(1, 16'h0000, 1, 1, 1'b0);
        wait_bif_en(ok);
        bif.REQ_VALID[0] = 1'b0;
        serve(1'b0, 1, 0, 1'b0, last);
        push_exp(1, 0, last + 4);
        push_exp(0, 1, -1);
        wait_bif_en(ok);
        bif.REQ_VALID[1] = 1'b0;
        serve(1'b0, 1, 0, 1'b0, last);
        push_exp(1, 1, last + 4);
        wait_empty("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/sfa_bif_sched.md
Name: sfa_bif_sched

Overview:
- Round-robin scheduler that shares one BRAM interface engine (BIF) between NREQ requesters.
- Each requester submits a job descriptor: INDEX, SIZE, STRIDE, MODE.
- The scheduler validates the descriptor, drives the BIF configuration port, pulses BIF_EN, and tracks stream beats to detect completion. It returns a per-requester DONE or ERR pulse.
- GRANT tells the external stream mux which requester owns the BIF streams.

Parameters:
- NREQ, 2, number of requesters (2..4).

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  synchronous active-low reset
- REQ_VALID  in  NREQ  per-requester job request
- REQ_READY  out  NREQ  one-hot descriptor accept pulse
- REQ_INDEX  in  16*NREQ  packed start byte address; requester k at bits [16k+15:16k]
- REQ_SIZE  in  16*NREQ  packed element count
- REQ_STRIDE  in  16*NREQ  packed element stride
- REQ_MODE  in  NREQ  0 = BRAM->stream read, 1 = stream->BRAM write
- DONE  out  NREQ  one-cycle completion pulse
- ERR  out  NREQ  one-cycle reject pulse
- GRANT  out  NREQ  one-hot owner of the current job; 0 when idle
- BUSY  out  1  high from accept until DONE or ERR
- BIF_EN  out  1  one-cycle start pulse to the BIF
- INDEX, SIZE, STRIDE  out  16 each  BIF configuration
- MODE  out  1  BIF mode
- mBIF_tvalid, mBIF_tready  in  1 each  tap of the BIF read stream
- sBIR_tvalid, sBIR_tready  in  1 each  tap of the BIF write stream

Behaviour:
- Reset (ARESETN=0 at a rising edge): the following are all 0, and state is IDLE:
  - REQ_READY, DONE, ERR, GRANT, BUSY, BIF_EN
  - INDEX, SIZE, STRIDE, MODE
  - the round-robin pointer, which makes requester 0 highest priority first.
- Reset mid-job aborts the job with no DONE. The BIF shares the same reset and returns to its idle state.
- All outputs are registered.
- States: IDLE, CHECK, START, RUN, DRAIN, FIN.
- IDLE:
  - Scan REQ_VALID starting at (last granted + 1) mod NREQ.
  - On a winner k: latch its descriptor into INDEX/SIZE/STRIDE/MODE, pulse REQ_READY[k] for 1 cycle, set GRANT = onehot(k), set BUSY, go CHECK.
- CHECK:
  - Compute in 19 bits: END = INDEX + 4*SIZE, LIM = END + 4*STRIDE.
  - Reject if SIZE==0, STRIDE==0, or LIM > 65536. These would give a zero-beat run, a BIF hang, or 16-bit address wrap.
  - On reject: go FIN with ERR flagged; BIF_EN is never asserted.
  - Otherwise: ACC <= INDEX, go START.
- START: BIF_EN=1 for exactly this cycle, then go RUN.
- RUN:
  - A beat is mBIF_tvalid&mBIF_tready when MODE=0, or sBIR_tvalid&sBIR_tready when MODE=1. The other stream's taps are ignored.
  - On each beat: ACC <= ACC + 4*STRIDE.
  - When ACC + 4*STRIDE >= END on a beat: load the drain counter with 2 (MODE=0) or 3 (MODE=1), go DRAIN.
  - Expected beat count is ceil(SIZE/STRIDE).
- DRAIN: decrement the counter each cycle; at 0 go FIN. This covers the BIF's return to its fetch state: 2 cycles after the last read handshake, 3 after the last write handshake.
- FIN:
  - Pulse DONE[k] or ERR[k] for 1 cycle.
  - Record the pointer = k.
  - Clear GRANT and BUSY; INDEX/SIZE/STRIDE/MODE hold their values.
  - Go IDLE. The next START can occur no earlier than 3 cycles after FIN (IDLE, CHECK, START).
- Configuration outputs are stable from START through FIN. The BIF re-reads them every cycle.
- A requester may drop REQ_VALID after REQ_READY. Its descriptor inputs are don't-care after acceptance.
- Simultaneous REQ_VALID from several requesters resolves purely round-robin. A requester that keeps REQ_VALID high re-arbitrates only after its FIN.
- Beats seen in IDLE, CHECK, START, DRAIN or FIN are ignored.
- There is no timeout: a stalled stream holds RUN indefinitely.

Test Plan:
1. Req0 read: INDEX=0x0010, SIZE=4, STRIDE=1; tready always 1 -> one BIF_EN pulse, 4 mBIF beats, DONE[0] 3 cycles after the 4th beat, GRANT=01 for the whole job.
2. Req1 write: INDEX=0, SIZE=5, STRIDE=2; tvalid always 1 -> 3 sBIR beats, DONE[1] 4 cycles after the 3rd beat.
3. Both REQ_VALID held, 3 short jobs each -> grants alternate 0,1,0,1,0,1; no BIF_EN ever pulses while BUSY is already high from a previous job.
4. Error descriptors: SIZE=0, STRIDE=0, and INDEX=0xFFF0/SIZE=4/STRIDE=1 (LIM=65540) -> ERR pulse 2 cycles after REQ_READY, BIF_EN stays 0.
5. Read with mBIF_tready toggling 1-in-3 cycles, SIZE=3, STRIDE=1 -> exactly 3 counted beats, DONE only after the 3rd handshake plus drain.
6. ARESETN low during RUN of a write job -> all outputs 0 the next cycle, no DONE; next request starts at requester 0.
